// File: rtl/sdram_word_bridge_pkg.sv
// Shared types and constants for the 32-bit word to 16-bit SDRAM bridge.
package sdram_word_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI,
    RESP
  } bridge_state_t;

  localparam int SDRAM_WINDOW_BIT = 24;
  localparam int SDRAM_ADDR_W     = 23;
  localparam int HALF_W           = 16;
  localparam int WORD_ADDR_W      = 24;

  // Word address holds byte address [25:2]; the halfword address is byte [23:1].
  function automatic logic [SDRAM_ADDR_W-1:0] half_addr(input logic [SDRAM_ADDR_W-2:0] row,
                                                         input logic                    hi);
    return {row, hi};
  endfunction

endpackage

// File: rtl/sdram_word_bridge_if.sv
// Word-access request/response bus between the memory-port manager and the bridge.
interface sdram_word_bridge_if;
  logic        word_req;
  logic        word_ready;
  logic        word_we;
  logic [23:0] word_addr;
  logic [31:0] word_wdata;
  logic [31:0] word_rdata;
  logic        word_done;
  logic        word_err;

  modport master (
    output word_req, word_we, word_addr, word_wdata,
    input  word_ready, word_rdata, word_done, word_err
  );

  modport slave (
    input  word_req, word_we, word_addr, word_wdata,
    output word_ready, word_rdata, word_done, word_err
  );
endinterface

// File: rtl/sdram_word_bridge_sat_counter.sv
// Up-counter with synchronous clear that saturates at LIMIT; tc is high while at LIMIT.
module sat_counter #(
  parameter int W     = 11,
  parameter int LIMIT = 1022
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == LIM);
endmodule

// File: rtl/sdram_word_bridge.sv
// Splits one 32-bit word access into two 16-bit SDRAM transactions (low then high),
// reassembles reads, and reports completion with a one-cycle done pulse plus error flag.
module sdram_word_bridge
  import sdram_word_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CTR_W          = 11
) (
  input  logic                    clk,
  input  logic                    rst_l,
  sdram_word_bridge_if.slave      word,
  input  logic                    SDRAM_ready,
  output logic                    SDRAM_as,
  output logic                    SDRAM_rw,
  output logic [SDRAM_ADDR_W-1:0] SDRAM_addr,
  output logic [HALF_W-1:0]       SDRAM_data_write,
  input  logic [HALF_W-1:0]       SDRAM_data_read,
  input  logic                    SDRAM_done
);
  bridge_state_t           state;
  logic                    lat_we;
  logic [SDRAM_ADDR_W-2:0] lat_row;
  logic [HALF_W-1:0]       lat_whi;
  logic [2*HALF_W-1:0]     rbuf;
  logic                    done_q;
  logic                    err_q;
  logic                    issuing;
  logic                    waiting;
  logic                    out_of_window;
  logic                    tmo_tc;

  assign issuing       = ((state == ISSUE_LO) || (state == ISSUE_HI)) && SDRAM_ready;
  assign waiting       = (state == WAIT_LO) || (state == WAIT_HI);
  assign out_of_window = |word.word_addr[WORD_ADDR_W-1:SDRAM_WINDOW_BIT-2];

  assign SDRAM_as        = issuing;
  assign word.word_ready = (state == IDLE);
  assign word.word_rdata = rbuf;
  assign word.word_done  = done_q;
  assign word.word_err   = err_q;

  // tc is reached when the next idle wait cycle would take the count to TIMEOUT_CYCLES-1.
  sat_counter #(
    .W     (CTR_W),
    .LIMIT (TIMEOUT_CYCLES - 2)
  ) u_tmo (
    .clk   (clk),
    .rst_l (rst_l),
    .clr   (issuing),
    .inc   (waiting && !SDRAM_done),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state            <= IDLE;
      lat_we           <= 1'b0;
      lat_row          <= '0;
      lat_whi          <= '0;
      rbuf             <= '0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      SDRAM_rw         <= 1'b0;
      SDRAM_addr       <= '0;
      SDRAM_data_write <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (word.word_req) begin
            lat_we  <= word.word_we;
            lat_row <= word.word_addr[SDRAM_ADDR_W-2:0];
            lat_whi <= word.word_wdata[2*HALF_W-1:HALF_W];
            rbuf    <= '0;
            if (out_of_window) begin
              state  <= RESP;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state            <= ISSUE_LO;
              SDRAM_rw         <= word.word_we;
              SDRAM_addr       <= half_addr(word.word_addr[SDRAM_ADDR_W-2:0], 1'b0);
              SDRAM_data_write <= word.word_we ? word.word_wdata[HALF_W-1:0] : '0;
            end
          end
        end
        ISSUE_LO: if (SDRAM_ready) state <= WAIT_LO;
        WAIT_LO: begin
          if (SDRAM_done) begin
            if (!lat_we) rbuf[HALF_W-1:0] <= SDRAM_data_read;
            state            <= ISSUE_HI;
            SDRAM_addr       <= half_addr(lat_row, 1'b1);
            SDRAM_data_write <= lat_we ? lat_whi : '0;
          end
        end
        ISSUE_HI: if (SDRAM_ready) state <= WAIT_HI;
        WAIT_HI: begin
          if (SDRAM_done) begin
            if (!lat_we) rbuf[2*HALF_W-1:HALF_W] <= SDRAM_data_read;
            state            <= RESP;
            done_q           <= 1'b1;
            SDRAM_rw         <= 1'b0;
            SDRAM_addr       <= '0;
            SDRAM_data_write <= '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A done arriving on the terminal count takes the normal path above.
      if (waiting && !SDRAM_done && tmo_tc) begin
        state            <= RESP;
        done_q           <= 1'b1;
        err_q            <= 1'b1;
        rbuf             <= '0;
        SDRAM_rw         <= 1'b0;
        SDRAM_addr       <= '0;
        SDRAM_data_write <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_word_bridge.sv
// Directed bench: table of word accesses against a simple SDRAM responder, plus timeout/reset/ready sequences.
module tb_sdram_word_bridge;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  sdram_word_bridge_if wif ();

  logic        SDRAM_ready = 1'b1;
  logic        SDRAM_as;
  logic        SDRAM_rw;
  logic [22:0] SDRAM_addr;
  logic [15:0] SDRAM_data_write;
  logic [15:0] SDRAM_data_read = 16'h0;
  logic        SDRAM_done = 1'b0;

  sdram_word_bridge #(.TIMEOUT_CYCLES(TO), .CTR_W(5)) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .word             (wif.slave),
    .SDRAM_ready      (SDRAM_ready),
    .SDRAM_as         (SDRAM_as),
    .SDRAM_rw         (SDRAM_rw),
    .SDRAM_addr       (SDRAM_addr),
    .SDRAM_data_write (SDRAM_data_write),
    .SDRAM_data_read  (SDRAM_data_read),
    .SDRAM_done       (SDRAM_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder and monitors, all sampling at the falling edge.
  int          st_n = 0;
  logic [22:0] st_addr [64];
  logic [15:0] st_dat  [64];
  logic        st_rw   [64];
  int          st_cyc  [64];
  int          dn_n = 0;
  int          dn_cyc = 0;
  logic        dn_err = 1'b0;
  logic [31:0] dn_rdata = 32'h0;
  int          served = 0;
  int          model_limit = 1000000;
  int          model_dly = 1;
  int          rd_base = 0;
  int          pend = 0;
  logic [15:0] pend_dat = 16'h0;
  logic [15:0] rd_dat [2];
  logic        force_done = 1'b0;

  always @(negedge clk) begin
    SDRAM_done = force_done;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        SDRAM_done      = 1'b1;
        SDRAM_data_read = pend_dat;
      end
    end
    if (SDRAM_as) begin
      if (st_n < 64) begin
        st_addr[st_n] = SDRAM_addr;
        st_dat[st_n]  = SDRAM_data_write;
        st_rw[st_n]   = SDRAM_rw;
        st_cyc[st_n]  = cyc;
      end
      st_n = st_n + 1;
      if (served < model_limit) begin
        pend     = model_dly;
        pend_dat = rd_dat[(served - rd_base) % 2];
        served   = served + 1;
      end
    end
    if (wif.word_done) begin
      dn_n     = dn_n + 1;
      dn_cyc   = cyc;
      dn_err   = wif.word_err;
      dn_rdata = wif.word_rdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [23:0] a, input logic [31:0] d, output int acc);
    wif.word_req   = 1'b1;
    wif.word_we    = we;
    wif.word_addr  = a;
    wif.word_wdata = d;
    acc = -1;
    for (int i = 0; i < 60 && acc < 0; i++) begin
      if (wif.word_ready) acc = cyc;
      tick();
    end
    wif.word_req = 1'b0;
    if (acc < 0) fail_now("accept");
  endtask

  task automatic wait_done(input int db, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dn_n > db) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("done_wait");
  endtask

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [15:0] rlo, rhi;
    int          dly;
    int          nst;
    logic [22:0] alo, ahi;
    logic [15:0] dlo, dhi;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tv [8];

  initial begin
    int  sb, db, acc;
    bit  ok;

    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  sb, db, acc;
    bit  ok;

    tv[0] = '{1'b1, 24'h000010, 32'hDEADBEEF, 16'h0,    16'h0,    2,  2, 23'h000020, 23'h000021, 16'hBEEF, 16'hDEAD, 1'b0, 32'h0,        7};
    tv[1] = '{1'b0, 24'h000010, 32'h0,        16'h5678, 16'h1234, 1,  2, 23'h000020, 23'h000021, 16'h0,    16'h0,    1'b0, 32'h12345678, 5};
    tv[2] = '{1'b1, 24'h3FFFFF, 32'h12345678, 16'h0,    16'h0,    1,  2, 23'h7FFFFE, 23'h7FFFFF, 16'h5678, 16'h1234, 1'b0, 32'h0,        5};
    tv[3] = '{1'b0, 24'h200001, 32'h0,        16'hAAAA, 16'h5555, 3,  2, 23'h400002, 23'h400003, 16'h0,    16'h0,    1'b0, 32'h5555AAAA, 9};
    tv[4] = '{1'b0, 24'h800000, 32'h0,        16'h0,    16'h0,    1,  0, 23'h0,      23'h0,      16'h0,    16'h0,    1'b1, 32'h0,        1};
    tv[5] = '{1'b1, 24'h400000, 32'hA5A5A5A5, 16'h0,    16'h0,    1,  0, 23'h0,      23'h0,      16'h0,    16'h0,    1'b1, 32'h0,        1};
    tv[6] = '{1'b0, 24'h12AB34, 32'h0,        16'h0F0F, 16'hF0F0, 15, 2, 23'h255668, 23'h255669, 16'h0,    16'h0,    1'b0, 32'hF0F00F0F, 33};
    tv[7] = '{1'b0, 24'hC00005, 32'h0,        16'h0,    16'h0,    1,  0, 23'h0,      23'h0,      16'h0,    16'h0,    1'b1, 32'h0,        1};

    wif.word_req   = 1'b0;
    wif.word_we    = 1'b0;
    wif.word_addr  = 24'h0;
    wif.word_wdata = 32'h0;
    rd_dat[0]      = 16'h0;
    rd_dat[1]      = 16'h0;

    // Reset values
    tick();
    tick();
    chk("rst_ready", wif.word_ready, 1);
    chk("rst_done",  wif.word_done, 0);
    chk("rst_err",   wif.word_err, 0);
    chk("rst_rdata", wif.word_rdata, 0);
    chk("rst_as",    SDRAM_as, 0);
    chk("rst_addr",  SDRAM_addr, 0);
    rst_l = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      sb        = st_n;
      db        = dn_n;
      rd_base   = served;
      rd_dat[0] = tv[i].rlo;
      rd_dat[1] = tv[i].rhi;
      model_dly = tv[i].dly;
      do_req(tv[i].we, tv[i].addr, tv[i].wdata, acc);
      wait_done(db, 80, ok);
      chk($sformatf("v%0d_done_cnt", i), dn_n - db, 1);
      if (ok) begin
        chk($sformatf("v%0d_latency", i), dn_cyc - acc, tv[i].lat);
        chk($sformatf("v%0d_err", i), dn_err, tv[i].err);
        chk($sformatf("v%0d_rdata", i), dn_rdata, tv[i].rdata);
      end
      chk($sformatf("v%0d_strobes", i), st_n - sb, tv[i].nst);
      for (int k = 0; k < tv[i].nst && k < 2; k++) begin
        chk($sformatf("v%0d_s%0d_addr", i, k), st_addr[sb+k], (k == 0) ? tv[i].alo : tv[i].ahi);
        chk($sformatf("v%0d_s%0d_data", i, k), st_dat[sb+k], (k == 0) ? tv[i].dlo : tv[i].dhi);
        chk($sformatf("v%0d_s%0d_rw", i, k), st_rw[sb+k], tv[i].we);
      end
      chk($sformatf("v%0d_done_pulse", i), wif.word_done, 0);
      chk($sformatf("v%0d_ready_after", i), wif.word_ready, 1);
      chk($sformatf("v%0d_addr_idle", i), SDRAM_addr, 0);
    end

    // Read data holds until the next accept, then clears
    model_dly = 1;
    rd_base   = served;
    rd_dat[0] = 16'h1111;
    rd_dat[1] = 16'h2222;
    db = dn_n;
    do_req(1'b0, 24'h000001, 32'h0, acc);
    wait_done(db, 40, ok);
    repeat (4) tick();
    chk("hold_rdata", wif.word_rdata, 32'h22221111);
    db = dn_n;
    do_req(1'b1, 24'h000002, 32'h55AA55AA, acc);
    chk("hold_clear", wif.word_rdata, 0);
    wait_done(db, 40, ok);

    // SDRAM_ready low for 7 cycles while the high half is waiting to issue
    sb = st_n;
    db = dn_n;
    rd_base   = served;
    rd_dat[0] = 16'h3333;
    rd_dat[1] = 16'h4444;
    do_req(1'b0, 24'h000008, 32'h0, acc);
    tick();
    SDRAM_ready = 1'b0;
    repeat (7) tick();
    chk("rdy_no_strobe", st_n - sb, 1);
    SDRAM_ready = 1'b1;
    wait_done(db, 40, ok);
    chk("rdy_strobes", st_n - sb, 2);
    chk("rdy_hi_cyc", st_cyc[sb+1] - acc, 9);
    chk("rdy_hi_addr", st_addr[sb+1], 23'h000011);
    chk("rdy_err", dn_err, 0);
    chk("rdy_rdata", dn_rdata, 32'h44443333);
    chk("rdy_latency", dn_cyc - acc, 11);

    // Timeout on the low half: no done ever returned
    sb = st_n;
    db = dn_n;
    model_limit = served;
    do_req(1'b0, 24'h000100, 32'h0, acc);
    wait_done(db, 60, ok);
    chk("tlo_strobes", st_n - sb, 1);
    chk("tlo_delay", dn_cyc - st_cyc[sb], 16);
    chk("tlo_err", dn_err, 1);
    chk("tlo_rdata", dn_rdata, 0);
    repeat (3) tick();
    chk("tlo_no_hi", st_n - sb, 1);

    // Timeout on the high half after the low half was captured
    sb = st_n;
    db = dn_n;
    rd_base     = served;
    rd_dat[0]   = 16'hABCD;
    rd_dat[1]   = 16'h0;
    model_limit = served + 1;
    do_req(1'b0, 24'h000200, 32'h0, acc);
    wait_done(db, 60, ok);
    chk("thi_strobes", st_n - sb, 2);
    chk("thi_delay", dn_cyc - st_cyc[sb+1], 16);
    chk("thi_err", dn_err, 1);
    chk("thi_rdata", dn_rdata, 0);
    model_limit = 1000000;

    // Reset while in WAIT_HI; the pending completion then arrives in IDLE
    sb = st_n;
    db = dn_n;
    rd_base   = served;
    rd_dat[0] = 16'h7777;
    rd_dat[1] = 16'h8888;
    model_dly = 3;
    do_req(1'b0, 24'h000020, 32'h0, acc);
    for (int i = 0; i < 40 && (st_n - sb) < 2; i++) tick();
    if ((st_n - sb) < 2) fail_now("rst_hi_strobe");
    rst_l = 1'b0;
    #1;
    chk("mid_rst_ready", wif.word_ready, 1);
    chk("mid_rst_done",  wif.word_done, 0);
    chk("mid_rst_err",   wif.word_err, 0);
    chk("mid_rst_rdata", wif.word_rdata, 0);
    chk("mid_rst_as",    SDRAM_as, 0);
    chk("mid_rst_rw",    SDRAM_rw, 0);
    chk("mid_rst_addr",  SDRAM_addr, 0);
    chk("mid_rst_wdat",  SDRAM_data_write, 0);
    tick();
    rst_l = 1'b1;
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (6) tick();
    chk("stray_no_done", dn_n - db, 0);
    chk("stray_ready", wif.word_ready, 1);
    chk("stray_no_strobe", st_n - sb, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
